cut_host_streamer: RTL and testbench
====================================

// Module: cut_host_streamer
// PURPOSE
// Host-side counterpart of the CUT I/O interface controller: streams one 48-word input vector into
// the CUT (val_input/din, paced by re_i), then captures the 16 result words the CUT emits on we/dout
// into a result buffer. Sits between the vector/result memories and the cut_io_interface ports.
// One start -> one full vector/result transaction, with timeout protection.
// PARAMETERS
// DATA_W   16    width of input and result words
// N_IN     48    input words per vector (matches CUT input depth)
// N_OUT    16    result words per vector (matches CUT output depth)
// TIMEOUT  1023  max cycles in WAIT_RES+RECV before aborting (counter width = $clog2(TIMEOUT+1))
// PORTS
// clk          in   1              system clock
// rst          in   1              asynchronous active-low reset
// start        in   1              1-cycle request; sampled only in IDLE
// busy         out  1              high from cycle after accepted start until DONE entered
// done         out  1              high in DONE state, held until next accepted start
// timeout_err  out  1              set with done when < N_OUT words captured; cleared on start
// vec_rd_en    out  1              vector memory read strobe
// vec_addr     out  $clog2(N_IN)   vector memory read address; data returned 1 cycle later
// vec_data     in   DATA_W         vector memory read data
// re_i         in   1              CUT ready-for-input (1 = may present a word)
// val_input    out  1              input word valid to CUT (registered)
// din          out  DATA_W         input word to CUT (registered)
// we           in   1              CUT result word valid
// dout         in   DATA_W         CUT result word
// res_we       out  1              result memory write strobe (registered)
// res_addr     out  $clog2(N_OUT)  result memory write address
// res_data     out  DATA_W         result memory write data
// BEHAVIOUR
// - Async reset: state=IDLE; all outputs 0 (busy, done, timeout_err, vec_rd_en, vec_addr, val_input,
//   din, res_we, res_addr, res_data); all counters 0. Reset mid-transaction aborts with no done.
// - FSM: IDLE -start-> SEND -N_IN words sent-> WAIT_RES -first we-> RECV -N_OUT captured-> DONE;
//   WAIT_RES/RECV -timeout-> DONE; DONE -start-> SEND (DONE otherwise holds). start ignored when busy.
// - SEND: fetch index f (0..N_IN-1) issues vec_rd_en, vec_addr=f; returned word lands in a 1-entry
//   hold register. Next fetch issued only if hold is empty or being consumed this cycle (no overrun).
// - Word k is presented (val_input=1, din=word k) the cycle after hold valid && re_i==1.
//   re_i==0 stalls: val_input=0 and hold kept; no word dropped or duplicated.
// - val_input is high in exactly N_IN cycles per transaction, words in address order 0..N_IN-1.
// - SEND->WAIT_RES the cycle after the N_IN-th val_input pulse; val_input=0 from then on.
// - WAIT_RES/RECV: each cycle with we==1 captures dout: res_we=1, res_data=dout, res_addr=capture
//   index, on the next cycle (latency 1). Index 0..N_OUT-1; after N_OUT captures -> DONE (next cycle).
// - we==1 outside WAIT_RES/RECV, or beyond N_OUT captures, is ignored (no res_we).
// - Timeout counter starts at 0 on entering WAIT_RES, +1 per cycle; at TIMEOUT with capture count
//   < N_OUT -> DONE with timeout_err=1. N_OUT-th capture and timeout same cycle: capture wins, no err.
// - Accepted start clears done and timeout_err and resets fetch/send/capture/timeout counters.
// TESTING
// - Reset, start, re_i=1 constant: vec_addr 0..47 in order; val_input high 48 cycles; din = vec[k].
// - re_i toggled 1/0 every 3 cycles during SEND -> still exactly 48 val_input pulses, no gaps in data
//   order, no duplicates; no vec_rd_en while hold full and re_i=0.
// - Model CUT drives we high 16 cycles with dout=0xA000+i -> res_addr 0..15, res_data 0xA000..0xA00F,
//   done=1, timeout_err=0, busy=0.
// - CUT drives only 10 we pulses, TIMEOUT=64 -> done=1, timeout_err=1 64 cycles after WAIT_RES entry;
//   10 results written.
// - start pulsed during SEND and RECV -> ignored; we pulses before WAIT_RES -> no res_we.
// - rst asserted mid-SEND (word 20) -> all outputs 0 immediately; new start replays from addr 0.

Source files
------------

// File: rtl/cut_host_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : cut_host_streamer_if
// Purpose  : Bundles the vector-memory read port, the CUT input/output
//            handshake and the result-memory write port of the host streamer.
// Revision : 1.0  initial release
// ============================================================================
interface cut_host_streamer_if #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 48,
    parameter int N_OUT  = 16
);
    logic                      vec_rd_en;
    logic [$clog2(N_IN)-1:0]   vec_addr;
    logic [DATA_W-1:0]         vec_data;
    logic                      re_i;
    logic                      val_input;
    logic [DATA_W-1:0]         din;
    logic                      we;
    logic [DATA_W-1:0]         dout;
    logic                      res_we;
    logic [$clog2(N_OUT)-1:0]  res_addr;
    logic [DATA_W-1:0]         res_data;

    // Streamer side
    modport master (
        output vec_rd_en, vec_addr,
        input  vec_data,
        input  re_i,
        output val_input, din,
        input  we, dout,
        output res_we, res_addr, res_data
    );

    // Memories / CUT side
    modport slave (
        input  vec_rd_en, vec_addr,
        output vec_data,
        output re_i,
        input  val_input, din,
        output we, dout,
        input  res_we, res_addr, res_data
    );
endinterface
`default_nettype wire

// File: rtl/cut_host_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cut_host_streamer
// Purpose  : Streams one N_IN-word vector from the vector memory into the CUT
//            (paced by re_i), then captures N_OUT result words from the CUT
//            into the result memory, with a timeout on the result phase.
// Revision : 1.0  initial release
// ============================================================================
module cut_host_streamer #(
    parameter int DATA_W  = 16,
    parameter int N_IN    = 48,
    parameter int N_OUT   = 16,
    parameter int TIMEOUT = 1023
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    cut_host_streamer_if.master bus
);
    localparam int AW_IN  = $clog2(N_IN);
    localparam int CW_IN  = $clog2(N_IN + 1);
    localparam int AW_OUT = $clog2(N_OUT);
    localparam int CW_OUT = $clog2(N_OUT + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);

    localparam logic [CW_IN-1:0]  N_IN_C   = CW_IN'(N_IN);
    localparam logic [CW_OUT-1:0] N_OUT_C  = CW_OUT'(N_OUT);
    localparam logic [CW_OUT-1:0] LAST_CAP = CW_OUT'(N_OUT - 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_WAIT_RES = 3'd2,
        S_RECV     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [CW_IN-1:0]    fetch_cnt;
    logic [CW_IN-1:0]    send_cnt;
    logic                rd_pending;
    logic                hold_valid;
    logic [DATA_W-1:0]   hold_data;
    logic [CW_OUT-1:0]   cap_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic                val_input_q;
    logic [DATA_W-1:0]   din_q;
    logic                res_we_q;
    logic [AW_OUT-1:0]   res_addr_q;
    logic [DATA_W-1:0]   res_data_q;

    logic                start_ok;
    logic                in_res_phase;
    logic                consume;
    logic                issue;
    logic                capture;
    logic                last_capture;
    logic                tmo_hit;

    assign start_ok     = start && ((state == S_IDLE) || (state == S_DONE));
    assign in_res_phase = (state == S_WAIT_RES) || (state == S_RECV);
    // The held word moves to the CUT whenever the CUT is ready for it.
    assign consume      = (state == S_SEND) && hold_valid && bus.re_i;
    // A fetch may only be launched when the word it returns is guaranteed a
    // free hold slot: nothing in flight, and hold empty or leaving now.
    assign issue        = (state == S_SEND) && (fetch_cnt != N_IN_C) && !rd_pending
                          && (!hold_valid || consume);
    assign capture      = in_res_phase && bus.we && (cap_cnt != N_OUT_C);
    assign last_capture = capture && (cap_cnt == LAST_CAP);
    assign tmo_hit      = in_res_phase && (tmo_cnt == TMO_LAST);

    assign busy          = (state == S_SEND) || in_res_phase;
    assign done          = (state == S_DONE);
    assign bus.vec_rd_en = issue;
    assign bus.vec_addr  = fetch_cnt[AW_IN-1:0];
    assign bus.val_input = val_input_q;
    assign bus.din       = din_q;
    assign bus.res_we    = res_we_q;
    assign bus.res_addr  = res_addr_q;
    assign bus.res_data  = res_data_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; a final capture takes priority over a timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start_ok) state_nxt = S_SEND;
            S_SEND:     if (val_input_q && (send_cnt == N_IN_C)) state_nxt = S_WAIT_RES;
            S_WAIT_RES: begin
                if (last_capture || tmo_hit) state_nxt = S_DONE;
                else if (capture)            state_nxt = S_RECV;
            end
            S_RECV:     if (last_capture || tmo_hit) state_nxt = S_DONE;
            S_DONE:     if (start_ok) state_nxt = S_SEND;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Fetch/hold/send datapath, result capture, timeout counter and error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt   <= '0;
            send_cnt    <= '0;
            rd_pending  <= 1'b0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            cap_cnt     <= '0;
            tmo_cnt     <= '0;
            val_input_q <= 1'b0;
            din_q       <= '0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            timeout_err <= 1'b0;
        end else begin
            rd_pending  <= issue;
            val_input_q <= consume;
            res_we_q    <= capture;

            if (issue) fetch_cnt <= fetch_cnt + 1'b1;

            if (rd_pending) begin
                hold_valid <= 1'b1;
                hold_data  <= bus.vec_data;
            end else if (consume) begin
                hold_valid <= 1'b0;
            end

            if (consume) begin
                din_q    <= hold_data;
                send_cnt <= send_cnt + 1'b1;
            end

            if (capture) begin
                res_data_q <= bus.dout;
                res_addr_q <= cap_cnt[AW_OUT-1:0];
                cap_cnt    <= cap_cnt + 1'b1;
            end

            if (in_res_phase) tmo_cnt <= tmo_cnt + 1'b1;
            else              tmo_cnt <= '0;

            if (tmo_hit && !last_capture) timeout_err <= 1'b1;

            if (start_ok) begin
                fetch_cnt   <= '0;
                send_cnt    <= '0;
                cap_cnt     <= '0;
                rd_pending  <= 1'b0;
                hold_valid  <= 1'b0;
                timeout_err <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cut_host_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cut_host_streamer
// Purpose  : Directed self-checking bench for cut_host_streamer with a
//            registered vector memory model and a scripted CUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_cut_host_streamer;
    localparam int DATA_W  = 16;
    localparam int N_IN    = 48;
    localparam int N_OUT   = 16;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] vec_mem [N_IN];

    cut_host_streamer_if #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    cut_host_streamer #(
        .DATA_W  (DATA_W),
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Vector memory: registered read, data one cycle after the strobe
    always @(posedge clk) begin
        if (bus.vec_rd_en) bus.vec_data <= vec_mem[bus.vec_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        busy,          0);
        check({tag, "_done"},        done,          0);
        check({tag, "_timeout_err"}, timeout_err,   0);
        check({tag, "_vec_rd_en"},   bus.vec_rd_en, 0);
        check({tag, "_vec_addr"},    bus.vec_addr,  0);
        check({tag, "_val_input"},   bus.val_input, 0);
        check({tag, "_din"},         bus.din,       0);
        check({tag, "_res_we"},      bus.res_we,    0);
        check({tag, "_res_addr"},    bus.res_addr,  0);
        check({tag, "_res_data"},    bus.res_data,  0);
    endtask

    // One transaction: start, stream the vector, play the CUT result side.
    // Inputs are driven at the falling edge, outputs sampled 1 time unit later.
    task automatic run_txn(input bit re_toggle, input int n_res, input int res_delay,
                           input bit inject, input int abort_at);
        int fetched  = 0;
        int sent     = 0;
        int rcv      = 0;
        int issued   = 0;
        int wait_cnt = 0;
        int last_val = -1;
        int done_cyc = -1;
        bit mhold    = 1'b0;
        bit pend     = 1'b0;
        bit land;
        bit exp_val  = 1'b0;
        bit consume_m;
        bit chk_busy;
        bit inj_recv = 1'b0;

        start = 1'b1;
        for (int c = 0; c < 400 && done_cyc < 0; c++) begin
            @(negedge clk);
            chk_busy   = start;
            start      = 1'b0;
            bus.re_i   = re_toggle ? (((c / 3) % 2) == 0) : 1'b1;
            bus.we     = 1'b0;
            if (inject && c == 20) start = 1'b1;
            if (inject && issued == 5 && !inj_recv) begin
                start    = 1'b1;
                inj_recv = 1'b1;
            end
            if (sent == N_IN) wait_cnt++;
            if (inject && c == 30) begin
                bus.we   = 1'b1;
                bus.dout = 16'hDEAD;
            end else if (sent == N_IN && wait_cnt >= res_delay && issued < n_res) begin
                bus.we   = 1'b1;
                bus.dout = 16'hA000 + 16'(issued);
                issued++;
            end
            #1;
            if (c == 0) begin
                check("start_clears_done", done, 0);
                check("start_clears_err", timeout_err, 0);
            end
            if (chk_busy) check("busy_after_start", busy, 1);
            consume_m = mhold && bus.re_i;
            if (bus.vec_rd_en) begin
                check("vec_addr", bus.vec_addr, fetched);
                check("no_fetch_overrun", mhold && !consume_m, 0);
                fetched++;
            end
            check("val_input", bus.val_input, exp_val);
            if (bus.val_input) begin
                check("val_in_range", sent < N_IN, 1);
                if (sent < N_IN) check("din", bus.din, vec_mem[sent]);
                sent++;
                if (sent == N_IN) last_val = c;
            end
            if (bus.res_we) begin
                check("res_addr", bus.res_addr, rcv);
                check("res_data", bus.res_data, 32'hA000 + rcv);
                rcv++;
            end
            if (done) done_cyc = c;
            if (abort_at > 0 && sent == abort_at) return;
            land    = pend;
            pend    = bus.vec_rd_en;
            exp_val = consume_m;
            mhold   = land | (mhold & ~consume_m);
        end

        check("done_seen", done_cyc >= 0, 1);
        check("fetch_count", fetched, N_IN);
        check("val_count", sent, N_IN);
        check("res_count", rcv, n_res);
        check("done_final", done, 1);
        check("busy_final", busy, 0);
        check("timeout_err_final", timeout_err, n_res < N_OUT);
        if (n_res < N_OUT) check("timeout_latency", done_cyc - last_val, TIMEOUT + 1);

        @(negedge clk);
        bus.we   = 1'b1;
        bus.dout = 16'hBEEF;
        @(negedge clk);
        bus.we   = 1'b0;
        #1;
        check("we_ignored_in_done", bus.res_we, 0);
        check("done_held", done, 1);
    endtask

    initial begin
        for (int i = 0; i < N_IN; i++) vec_mem[i] = 16'h3C00 + 16'(i * 37);
        rst      = 1'b0;
        start    = 1'b0;
        bus.re_i = 1'b0;
        bus.we   = 1'b0;
        bus.dout = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Steady re_i, full result set
        run_txn(1'b0, 16, 2, 1'b0, 0);
        // re_i 3-on/3-off, stray start in SEND and RECV, stray we in SEND
        run_txn(1'b1, 16, 2, 1'b1, 0);
        // Only 10 results: timeout path
        run_txn(1'b0, 10, 3, 1'b0, 0);
        // Reset in the middle of SEND
        run_txn(1'b0, 16, 2, 1'b0, 20);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        // Replay from address 0
        run_txn(1'b0, 16, 2, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
